stage_execute: RTL

Vector execute stage; sits directly upstream of stage_writeback and feeds it.
- Computes a lane-wise ALU result over vecSize lanes of registerSize bits.
- Registers the result and the memory/register-write control fields into the execute→writeback pipeline register.
- Single-cycle ops issue back-to-back; MUL is a 4-cycle iterative shift-add that stalls the upstream decode stage.

---
 rtl/stage_execute.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/stage_execute.sv
// -----------------------------------------------------------------------------
// stage_execute
//
// Vector execute stage feeding stage_writeback. Computes a lane-wise ALU
// result over vecSize lanes of registerSize bits and registers it, together
// with the memory/register-write control fields, into the execute->writeback
// pipeline register. Single-cycle ops issue back-to-back. MUL is an iterative
// shift-add taking one nibble of operand B per cycle (registerSize/4 cycles).
// While it iterates, the stage stalls the upstream decode stage.
//
// Handshake: decode presents an op with in_valid=1. The op is taken on a
// rising edge only when stall=0 and flush=0. While stall=1, decode holds its
// op unchanged, and the stage ignores in_valid and all op inputs. Writeback has
// no backpressure; out_valid=1 marks a real op for exactly one cycle.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 synchronous kill of the accepted/in-flight op
//   in_valid              decode presents an op this cycle
//   aluOp                 operation code (0 ADD .. 8 PASSB, 9-15 give 0)
//   useImm                operand B = in_imm broadcast to every lane
//   in_writeEnable        memory write request
//   in_writeMemFrom       forwarded to writeback
//   in_writeRegFrom       forwarded to writeback
//   in_imm                immediate
//   srcA, srcB            packed operand vectors, lane l at [l*RS +: RS]
//   stall                 upstream must hold its op (high while MUL iterates)
//   out_valid             writeback registers hold a real op
//   writeEnable           registered write request, 0 whenever out_valid=0
//   writeMemFrom          registered control field
//   writeRegFrom          registered control field
//   imm                   registered immediate
//   aluResult             registered lane-wise result
//   alu_operand1          registered operand A
//   alu_operand2          registered operand B after the useImm mux
//   dbg_state             FSM state (0 = IDLE, 1 = MUL)
// -----------------------------------------------------------------------------
module stage_execute #(
  parameter int vecSize      = 4,
  parameter int registerSize = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [3:0]                       aluOp,
  input  logic                             useImm,
  input  logic                             in_writeEnable,
  input  logic                             in_writeMemFrom,
  input  logic [1:0]                       in_writeRegFrom,
  input  logic [registerSize-1:0]          in_imm,
  input  logic [vecSize*registerSize-1:0]  srcA,
  input  logic [vecSize*registerSize-1:0]  srcB,
  output logic                             stall,
  output logic                             out_valid,
  output logic                             writeEnable,
  output logic                             writeMemFrom,
  output logic [1:0]                       writeRegFrom,
  output logic [registerSize-1:0]          imm,
  output logic [vecSize*registerSize-1:0]  aluResult,
  output logic [vecSize*registerSize-1:0]  alu_operand1,
  output logic [vecSize*registerSize-1:0]  alu_operand2,
  output logic                             dbg_state
);

  localparam int W    = registerSize;
  localparam int VW   = vecSize * registerSize;
  localparam int ITER = registerSize / 4;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_PASSB = 4'd8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // MUL iteration counter and per-lane accumulators
  logic [CW-1:0] cnt;
  logic [VW-1:0] acc;
  logic [VW-1:0] acc_nxt;

  // Operands and control captured when a MUL is accepted
  logic [VW-1:0] a_hold;
  logic [VW-1:0] b_hold;
  logic          we_hold;
  logic          wmf_hold;
  logic [1:0]    wrf_hold;
  logic [W-1:0]  imm_hold;

  // Single-cycle ALU path
  logic [VW-1:0] opb;
  logic [VW-1:0] alu_res;
  logic [W-1:0]  a_l;
  logic [W-1:0]  b_l;
  logic [W-1:0]  r_l;

  // MUL step temporaries
  logic [CW+1:0] sh;
  logic [W-1:0]  part_a;
  logic [3:0]    part_n;

  assign dbg_state = (state == S_MUL);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and stall (stall depends on state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && (aluOp == OP_MUL)) begin
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        stall = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane-wise single-cycle ALU with the useImm operand mux
  // ---------------------------------------------------------------------------
  always_comb begin
    opb     = '0;
    alu_res = '0;
    a_l     = '0;
    b_l     = '0;
    r_l     = '0;
    for (int l = 0; l < vecSize; l++) begin
      a_l = srcA[l*W +: W];
      b_l = useImm ? in_imm : srcB[l*W +: W];
      opb[l*W +: W] = b_l;
      case (aluOp)
        OP_ADD:   r_l = a_l + b_l;
        OP_SUB:   r_l = a_l - b_l;
        OP_AND:   r_l = a_l & b_l;
        OP_OR:    r_l = a_l | b_l;
        OP_XOR:   r_l = a_l ^ b_l;
        OP_SLL:   r_l = a_l << b_l[3:0];
        OP_SRL:   r_l = a_l >> b_l[3:0];
        OP_PASSB: r_l = b_l;
        default:  r_l = '0;  // MUL takes the iterative path; 9-15 give 0
      endcase
      alu_res[l*W +: W] = r_l;
    end
  end

  // ---------------------------------------------------------------------------
  // One shift-add step: acc += (A << 4*cnt) * B[4*cnt+3:4*cnt], mod 2^W
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_nxt = '0;
    sh      = {cnt, 2'b00};
    part_a  = '0;
    part_n  = '0;
    for (int l = 0; l < vecSize; l++) begin
      part_a = a_hold[l*W +: W] << sh;
      part_n = 4'(b_hold[l*W +: W] >> sh);
      acc_nxt[l*W +: W] = acc[l*W +: W] + part_a * {{(W-4){1'b0}}, part_n};
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline register, MUL holding registers, counter and accumulators
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      writeEnable  <= 1'b0;
      writeMemFrom <= 1'b0;
      writeRegFrom <= '0;
      imm          <= '0;
      aluResult    <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      cnt          <= '0;
      acc          <= '0;
      a_hold       <= '0;
      b_hold       <= '0;
      we_hold      <= 1'b0;
      wmf_hold     <= 1'b0;
      wrf_hold     <= '0;
      imm_hold     <= '0;
    end else if (flush) begin
      // Kill whatever was accepted or in flight; other fields keep old values.
      out_valid   <= 1'b0;
      writeEnable <= 1'b0;
      cnt         <= '0;
    end else if (state == S_IDLE) begin
      if (in_valid && (aluOp == OP_MUL)) begin
        a_hold      <= srcA;
        b_hold      <= opb;
        we_hold     <= in_writeEnable;
        wmf_hold    <= in_writeMemFrom;
        wrf_hold    <= in_writeRegFrom;
        imm_hold    <= in_imm;
        acc         <= '0;
        cnt         <= '0;
        out_valid   <= 1'b0;
        writeEnable <= 1'b0;
      end else if (in_valid) begin
        out_valid    <= 1'b1;
        writeEnable  <= in_writeEnable;
        writeMemFrom <= in_writeMemFrom;
        writeRegFrom <= in_writeRegFrom;
        imm          <= in_imm;
        aluResult    <= alu_res;
        alu_operand1 <= srcA;
        alu_operand2 <= opb;
      end else begin
        // Bubble: writeEnable cleared so it can never write memory.
        out_valid   <= 1'b0;
        writeEnable <= 1'b0;
      end
    end else begin
      if (cnt == CNT_LAST) begin
        // Final iteration: the result goes straight to the output register.
        out_valid    <= 1'b1;
        writeEnable  <= we_hold;
        writeMemFrom <= wmf_hold;
        writeRegFrom <= wrf_hold;
        imm          <= imm_hold;
        aluResult    <= acc_nxt;
        alu_operand1 <= a_hold;
        alu_operand2 <= b_hold;
        acc          <= acc_nxt;
        cnt          <= '0;
      end else begin
        acc         <= acc_nxt;
        cnt         <= cnt + 1'b1;
        out_valid   <= 1'b0;
        writeEnable <= 1'b0;
      end
    end
  end

endmodule
